// File: rtl/simmem_bank_scheduler.sv
// Single-bank timing scheduler: arbitrates write/read address requests, tracks the open row,
// holds each burst for its row-dependent service time, then reports completion by internal ID.
// Latency: hit C=RowHitCost*beats, closed adds ActivationCost, conflict adds PrechargeCost too.
// Backpressure: one burst in flight; ready only in IDLE; done_valid_o held until done_ready_i.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   w_valid_i/w_ready_o/w_iid_i/w_addr_i/w_len_i   write request stream
//   r_valid_i/r_ready_o/r_iid_i/r_addr_i/r_len_i   read request stream
//   done_valid_o/done_ready_i/done_type_o/done_iid_o completion stream (0=write bank, 1=read bank)
//   hit_cnt_o/miss_cnt_o            saturating row-hit / row-miss statistics
module simmem_bank_scheduler #(
  parameter int RowIdWidth     = 9,
  parameter int RowHitCost     = 4,
  parameter int PrechargeCost  = 2,
  parameter int ActivationCost = 1,
  parameter int CntW           = 16,
  parameter int AxAddrWidth    = 19,
  parameter int AxLenWidth     = 8,
  parameter int WriteIidWidth  = 4,
  parameter int ReadIidWidth   = 3,
  parameter int WRspBankAddrW  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  input  logic [WriteIidWidth-1:0] w_iid_i,
  input  logic [AxAddrWidth-1:0]   w_addr_i,
  input  logic [AxLenWidth-1:0]    w_len_i,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  input  logic [ReadIidWidth-1:0]  r_iid_i,
  input  logic [AxAddrWidth-1:0]   r_addr_i,
  input  logic [AxLenWidth-1:0]    r_len_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic                     done_type_o,
  output logic [WRspBankAddrW-1:0] done_iid_o,
  output logic [CntW-1:0]          hit_cnt_o,
  output logic [CntW-1:0]          miss_cnt_o
);

  localparam logic WRSP_BANK  = 1'b0;
  localparam logic RDATA_BANK = 1'b1;
  localparam logic PRIO_READ  = 1'b0;
  localparam logic PRIO_WRITE = 1'b1;

  localparam int MaxBurstEffLen = 4;
  localparam int CW = $clog2(PrechargeCost + ActivationCost + RowHitCost * MaxBurstEffLen + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    ACCESS,
    DONE
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         acc_load_q;
  logic                  prio_q;
  logic                  open_valid_q;
  logic [RowIdWidth-1:0] open_row_q;
  logic [RowIdWidth-1:0] req_row_q;

  // Only len 0..2 is legal, so anything beyond 1 maps to the 4-beat case.
  function automatic logic [2:0] get_effective_burst_len(input logic [AxLenWidth-1:0] len);
    if (len == '0)
      return 3'd1;
    else if (len == AxLenWidth'(1))
      return 3'd2;
    else
      return 3'd4;
  endfunction

  logic                   idle;
  logic                   w_grant;
  logic                   r_grant;
  logic                   grant;
  logic [AxAddrWidth-1:0] g_addr;
  logic [AxLenWidth-1:0]  g_len;
  logic [RowIdWidth-1:0]  g_row;
  logic                   g_hit;
  logic [CW-1:0]          g_acc_load;
  logic                   unused_addr_lsbs;

  assign idle      = (state_q == IDLE);
  // The stream holding priority wins a tie; a lone requester always wins.
  assign r_ready_o = idle && r_valid_i && (!w_valid_i || prio_q == PRIO_READ);
  assign w_ready_o = idle && w_valid_i && (!r_valid_i || prio_q == PRIO_WRITE);
  assign r_grant   = r_valid_i && r_ready_o;
  assign w_grant   = w_valid_i && w_ready_o;
  assign grant     = r_grant || w_grant;

  assign g_addr     = r_grant ? r_addr_i : w_addr_i;
  assign g_len      = r_grant ? r_len_i : w_len_i;
  assign g_row      = g_addr[AxAddrWidth-1 -: RowIdWidth];
  assign g_hit      = open_valid_q && (g_row == open_row_q);
  assign g_acc_load = CW'(RowHitCost * int'(get_effective_burst_len(g_len)) - 1);

  // Column bits do not affect bank timing.
  assign unused_addr_lsbs = ^g_addr[AxAddrWidth-RowIdWidth-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_load_q   <= '0;
      prio_q       <= PRIO_READ;
      open_valid_q <= 1'b0;
      open_row_q   <= '0;
      req_row_q    <= '0;
      done_valid_o <= 1'b0;
      done_type_o  <= WRSP_BANK;
      done_iid_o   <= '0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            prio_q      <= ~prio_q;
            done_type_o <= r_grant ? RDATA_BANK : WRSP_BANK;
            done_iid_o  <= r_grant ? WRspBankAddrW'(r_iid_i) : WRspBankAddrW'(w_iid_i);
            req_row_q   <= g_row;
            acc_load_q  <= g_acc_load;
            if (g_hit) begin
              if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
              state_q <= ACCESS;
              cnt_q   <= g_acc_load;
            end else begin
              if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
              // Zero-cost phases are skipped; the row is opened on entry to ACCESS.
              if (open_valid_q && PrechargeCost > 0) begin
                state_q <= PRECHARGE;
                cnt_q   <= CW'(PrechargeCost - 1);
              end else if (ActivationCost > 0) begin
                state_q <= ACTIVATE;
                cnt_q   <= CW'(ActivationCost - 1);
              end else begin
                state_q      <= ACCESS;
                cnt_q        <= g_acc_load;
                open_row_q   <= g_row;
                open_valid_q <= 1'b1;
              end
            end
          end
        end
        PRECHARGE: begin
          if (cnt_q == '0) begin
            open_valid_q <= 1'b0;
            if (ActivationCost > 0) begin
              state_q <= ACTIVATE;
              cnt_q   <= CW'(ActivationCost - 1);
            end else begin
              state_q      <= ACCESS;
              cnt_q        <= acc_load_q;
              open_row_q   <= req_row_q;
              open_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACTIVATE: begin
          if (cnt_q == '0) begin
            state_q      <= ACCESS;
            cnt_q        <= acc_load_q;
            open_row_q   <= req_row_q;
            open_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q      <= DONE;
            done_valid_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (done_ready_i) begin
            state_q      <= IDLE;
            done_valid_o <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_bank_scheduler.sv
// Randomized scoreboard bench for simmem_bank_scheduler with directed row-hit/closed/conflict,
// done backpressure and mid-burst reset scenarios; a reference model predicts grants, costs
// and counters, and an independent monitor checks every completion against the queue.
module tb_simmem_bank_scheduler;

  localparam int AW = 19;
  localparam int LW = 8;
  localparam int RH = 4;
  localparam int PC = 2;
  localparam int AC = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          w_valid_i, w_ready_o;
  logic [3:0]    w_iid_i;
  logic [AW-1:0] w_addr_i;
  logic [LW-1:0] w_len_i;
  logic          r_valid_i, r_ready_o;
  logic [2:0]    r_iid_i;
  logic [AW-1:0] r_addr_i;
  logic [LW-1:0] r_len_i;
  logic          done_valid_o, done_ready_i, done_type_o;
  logic [3:0]    done_iid_o;
  logic [15:0]   hit_cnt_o, miss_cnt_o;

  simmem_bank_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_iid_i(w_iid_i),
    .w_addr_i(w_addr_i), .w_len_i(w_len_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_iid_i(r_iid_i),
    .r_addr_i(r_addr_i), .r_len_i(r_len_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_type_o(done_type_o), .done_iid_o(done_iid_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       typ;
    logic [3:0] iid;
    int         due;
    int         hits;
    int         misses;
  } exp_t;
  exp_t sb[$];

  // Reference model state (bank behaviour in terms of rows and cycle costs).
  bit       m_busy = 0;
  bit       m_prio = 0;          // 0 = read has priority
  bit       m_open_v = 0;
  bit [8:0] m_open_row = '0;
  int       m_hits = 0, m_misses = 0;
  int       m_grant_cyc = -1;
  int       hs_cyc = -1;         // negedge at which the monitor saw a done handshake pending
  int       last_grant = 0;      // 1 = write, 2 = read, decided at the last negedge

  // Pending requests held by the stimulus until the model says they were taken.
  bit w_pend = 0, r_pend = 0;
  int gen_mode = 0;              // 0 directed, 1 random, 2 both streams always valid
  int dr_mode = 1;               // 0 hold low, 1 high, 2 random

  function automatic logic [8:0] pick_row();
    case ($urandom % 4)
      0: return 9'h001;
      1: return 9'h002;
      2: return 9'h1FF;
      default: return 9'h005;
    endcase
  endfunction

  task automatic new_w();
    w_pend   = 1;
    w_iid_i  = 4'($urandom);
    w_addr_i = {pick_row(), 10'($urandom)};
    w_len_i  = LW'($urandom % 3);
  endtask

  task automatic new_r();
    r_pend   = 1;
    r_iid_i  = 3'($urandom);
    r_addr_i = {pick_row(), 10'($urandom)};
    r_len_i  = LW'($urandom % 3);
  endtask

  task automatic predict();
    bit       idle, exp_r, exp_w, hit;
    bit [8:0] row;
    int       beats, cost;
    exp_t     e;
    idle = !m_busy || (hs_cyc > m_grant_cyc && hs_cyc < cyc);
    if (idle) m_busy = 0;
    exp_r = idle && r_valid_i && (!w_valid_i || m_prio == 0);
    exp_w = idle && w_valid_i && (!r_valid_i || m_prio == 1);
    chk("r_ready", r_ready_o, exp_r);
    chk("w_ready", w_ready_o, exp_w);
    chk("ready_exclusive", w_ready_o & r_ready_o, 0);
    if (exp_r || exp_w) begin
      row   = exp_r ? r_addr_i[AW-1 -: 9] : w_addr_i[AW-1 -: 9];
      beats = 1 << (exp_r ? int'(r_len_i) : int'(w_len_i));
      hit   = m_open_v && row == m_open_row;
      cost  = RH * beats + (hit ? 0 : AC + (m_open_v ? PC : 0));
      if (hit) begin
        if (m_hits < 65535) m_hits++;
      end else begin
        if (m_misses < 65535) m_misses++;
      end
      e.typ    = exp_r;
      e.iid    = exp_r ? {1'b0, r_iid_i} : w_iid_i;
      e.due    = cyc + 1 + cost;
      e.hits   = m_hits;
      e.misses = m_misses;
      sb.push_back(e);
      m_open_v    = 1;
      m_open_row  = row;
      m_prio      = exp_r ? 1'b1 : 1'b0;
      m_busy      = 1;
      m_grant_cyc = cyc;
      last_grant  = exp_r ? 2 : 1;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (last_grant == 1) w_pend = 0;
    if (last_grant == 2) r_pend = 0;
    last_grant = 0;
    if (gen_mode == 1) begin
      if (!w_pend && $urandom % 3 == 0) new_w();
      if (!r_pend && $urandom % 3 == 0) new_r();
    end else if (gen_mode == 2) begin
      if (!w_pend) new_w();
      if (!r_pend) new_r();
    end
    done_ready_i = (dr_mode == 2) ? ($urandom % 4 != 0) : (dr_mode == 1);
    w_valid_i = w_pend;
    r_valid_i = r_pend;
    @(negedge clk_i);
    if (!rst_i) predict();
  endtask

  // Completion monitor.
  bit   in_done = 0;
  bit   hs_pending = 0;
  exp_t cur;

  always @(negedge clk_i) begin
    if (rst_i) begin
      in_done    = 0;
      hs_pending = 0;
    end else if (hs_pending) begin
      chk("done_drop_after_hs", done_valid_o, 0);
      hs_pending = 0;
    end else if (in_done) begin
      chk("done_valid_held", done_valid_o, 1);
      chk("done_iid_stable", done_iid_o, cur.iid);
      chk("done_type_stable", done_type_o, cur.typ);
      if (done_ready_i) begin
        hs_cyc = cyc; in_done = 0; hs_pending = 1;
      end
    end else if (done_valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_done", done_valid_o, 0);
      end else begin
        cur = sb.pop_front();
        chk("done_cycle", cyc, cur.due);
        chk("done_type", done_type_o, cur.typ);
        chk("done_iid", done_iid_o, cur.iid);
        chk("hit_cnt", hit_cnt_o, cur.hits);
        chk("miss_cnt", miss_cnt_o, cur.misses);
        in_done = 1;
        if (done_ready_i) begin
          hs_cyc = cyc; in_done = 0; hs_pending = 1;
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("done_timeout", done_valid_o, 1);
      void'(sb.pop_front());
    end
  end

  task automatic drain();
    int n = 0;
    while ((w_pend || r_pend || sb.size() > 0 || in_done || hs_pending) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL drain_timeout: traffic still outstanding after %0d cycles", n);
    end
  endtask

  task automatic issue_r(input logic [2:0] iid, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    r_pend = 1; r_iid_i = iid; r_addr_i = addr; r_len_i = len;
  endtask

  task automatic issue_w(input logic [3:0] iid, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    w_pend = 1; w_iid_i = iid; w_addr_i = addr; w_len_i = len;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_ready"}, w_ready_o, 0);
    chk({tag, "_r_ready"}, r_ready_o, 0);
    chk({tag, "_done_valid"}, done_valid_o, 0);
    chk({tag, "_done_type"}, done_type_o, 0);
    chk({tag, "_done_iid"}, done_iid_o, 0);
    chk({tag, "_hit_cnt"}, hit_cnt_o, 0);
    chk({tag, "_miss_cnt"}, miss_cnt_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1; w_valid_i = 0; r_valid_i = 0; done_ready_i = 1;
    w_iid_i = '0; w_addr_i = '0; w_len_i = '0;
    r_iid_i = '0; r_addr_i = '0; r_len_i = '0;
    #1;
    chk_reset_outputs("por");
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    rst_i = 0;

    // Closed row, hit with 2 beats, conflict with 4 beats, then a hit proving row 0x1FF is open.
    issue_r(3'd5, 19'h00400, 8'd0); drain();
    issue_r(3'd3, 19'h00410, 8'd1); drain();
    issue_w(4'd9, 19'h7FC00, 8'd2); drain();
    issue_w(4'd2, 19'h7FC10, 8'd0); drain();

    // Completion held off for well over 10 cycles with a competing request waiting.
    dr_mode = 0;
    issue_r(3'd7, 19'h7FC20, 8'd0);
    issue_w(4'd12, 19'h7FC40, 8'd0);
    repeat (20) step();
    dr_mode = 1;
    drain();

    // Reset in the middle of ACCESS of a conflict burst.
    issue_r(3'd6, 19'h00800, 8'd2);
    n = 0;
    while (sb.size() == 0 && n < 20) begin step(); n++; end
    repeat (6) step();
    @(posedge clk_i);
    #3;
    rst_i = 1; w_valid_i = 0; r_valid_i = 0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    w_pend = 0; r_pend = 0; last_grant = 0;
    m_busy = 0; m_prio = 0; m_open_v = 0; m_hits = 0; m_misses = 0;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 0;
    issue_r(3'd4, 19'h00800, 8'd0); drain();

    // Both streams valid on every cycle: strict alternation.
    gen_mode = 2; dr_mode = 1;
    repeat (120) step();
    gen_mode = 0; drain();

    // Random traffic with random completion backpressure.
    gen_mode = 1; dr_mode = 2;
    repeat (600) step();
    gen_mode = 0; dr_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
